// File: rtl/dpram_port_arbiter.sv
// Access controller in front of a true dual-port RAM: per-side valid/ready, same-address
// write conflicts serialized round-robin, aligned read-valid strobes, saturating conflict count.
module dpram_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    input  logic [DATA_W-1:0] ram_douta,
    output logic              ram_web,
    output logic [ADDR_W-1:0] ram_addrb,
    output logic [DATA_W-1:0] ram_dinb,
    input  logic [DATA_W-1:0] ram_doutb,
    input  logic              cnt_clr,
    output logic [15:0]       conflict_cnt
);

    logic              prio;
    logic              conflict;
    logic              fire_a;
    logic              fire_b;
    logic [RD_LAT:0]   rv_sr_a;
    logic [RD_LAT:0]   rv_sr_b;

    // Two reads of one address are harmless; only a write on either side forces serialization.
    assign conflict = req_a & req_b & (addr_a == addr_b) & (we_a | we_b);

    assign gnt_a  = ~rst & req_a & (~conflict | ~prio);
    assign gnt_b  = ~rst & req_b & (~conflict |  prio);
    assign fire_a = req_a & gnt_a;
    assign fire_b = req_b & gnt_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (conflict) begin
            prio <= ~prio;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_wea   <= 1'b0;
            ram_addra <= '0;
            ram_dina  <= '0;
        end else begin
            ram_wea <= fire_a & we_a;
            if (fire_a) begin
                ram_addra <= addr_a;
                ram_dina  <= wdata_a;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_web   <= 1'b0;
            ram_addrb <= '0;
            ram_dinb  <= '0;
        end else begin
            ram_web <= fire_b & we_b;
            if (fire_b) begin
                ram_addrb <= addr_b;
                ram_dinb  <= wdata_b;
            end
        end
    end

    // Bit 0 is set at the fire edge; bit RD_LAT lines up with the RAM data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_sr_a <= '0;
            rv_sr_b <= '0;
        end else begin
            rv_sr_a <= {rv_sr_a[RD_LAT-1:0], fire_a & ~we_a};
            rv_sr_b <= {rv_sr_b[RD_LAT-1:0], fire_b & ~we_b};
        end
    end

    assign rvalid_a = rv_sr_a[RD_LAT];
    assign rvalid_b = rv_sr_b[RD_LAT];
    assign rdata_a  = ram_douta;
    assign rdata_b  = ram_doutb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= 16'h0000;
        end else if (cnt_clr) begin
            conflict_cnt <= 16'h0000;
        end else if (conflict && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'h0001;
        end
    end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: RAM emulation, a queue-based reference model checked every
// negative edge, and directed scenarios with literal expectations.
module tb_dpram_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
    logic [DATA_W-1:0] wdata_a = '0, wdata_b = '0;
    logic              gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              ram_wea, ram_web;
    logic [ADDR_W-1:0] ram_addra, ram_addrb;
    logic [DATA_W-1:0] ram_dina, ram_dinb, ram_douta, ram_doutb;
    logic              cnt_clr = 1'b0;
    logic [15:0]       conflict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dpram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_douta(ram_douta),
        .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_dinb(ram_dinb), .ram_doutb(ram_doutb),
        .cnt_clr(cnt_clr), .conflict_cnt(conflict_cnt)
    );

    // RAM emulation: read-first, data valid RD_LAT edges after the sampling edge, less one
    logic [DATA_W-1:0] ram_mem [1024];
    logic [DATA_W-1:0] pa [RD_LAT];
    logic [DATA_W-1:0] pb [RD_LAT];
    initial for (int i = 0; i < 1024; i++) ram_mem[i] = '0;
    initial for (int i = 0; i < RD_LAT; i++) begin pa[i] = '0; pb[i] = '0; end
    always @(posedge clk) begin
        if (ram_wea) ram_mem[ram_addra] <= ram_dina;
        if (ram_web) ram_mem[ram_addrb] <= ram_dinb;
        pa[0] <= ram_mem[ram_addra];
        pb[0] <= ram_mem[ram_addrb];
        for (int i = 1; i < RD_LAT; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end
    assign ram_douta = pa[RD_LAT-1];
    assign ram_doutb = pb[RD_LAT-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model: abstract memory contents plus a queue of due read results per side
    typedef struct { int due; logic [DATA_W-1:0] d; } rd_t;
    rd_t               qa[$];
    rd_t               qb[$];
    logic [DATA_W-1:0] mm [1024];
    bit                m_prio;
    int                m_cnt;
    logic              m_wea, m_web;
    logic [ADDR_W-1:0] m_addra, m_addrb;
    logic [DATA_W-1:0] m_dina, m_dinb;
    int                cyc = 0;

    initial begin
        bit conf, fa, fb, ea, eb;
        for (int i = 0; i < 1024; i++) mm[i] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_gnt_a", gnt_a, 0);       chk("rst_gnt_b", gnt_b, 0);
                chk("rst_rvalid_a", rvalid_a, 0); chk("rst_rvalid_b", rvalid_b, 0);
                chk("rst_ram_a", {ram_wea, ram_addra, ram_dina}, 0);
                chk("rst_ram_b", {ram_web, ram_addrb, ram_dinb}, 0);
                chk("rst_cnt", conflict_cnt, 0);
                qa.delete(); qb.delete();
                m_prio = 0; m_cnt = 0; m_wea = 0; m_web = 0;
                m_addra = '0; m_addrb = '0; m_dina = '0; m_dinb = '0;
            end else begin
                ea = (qa.size() > 0) && (qa[0].due == cyc);
                eb = (qb.size() > 0) && (qb[0].due == cyc);
                chk("rvalid_a", rvalid_a, ea);
                chk("rvalid_b", rvalid_b, eb);
                if (ea) begin chk("rdata_a", rdata_a, qa[0].d); void'(qa.pop_front()); end
                if (eb) begin chk("rdata_b", rdata_b, qb[0].d); void'(qb.pop_front()); end
                chk("ram_a", {ram_wea, ram_addra, ram_dina}, {m_wea, m_addra, m_dina});
                chk("ram_b", {ram_web, ram_addrb, ram_dinb}, {m_web, m_addrb, m_dinb});
                chk("conflict_cnt", conflict_cnt, m_cnt[15:0]);
                conf = req_a && req_b && (addr_a == addr_b) && (we_a || we_b);
                fa = req_a && (!conf || !m_prio);
                fb = req_b && (!conf || m_prio);
                chk("gnt_a", gnt_a, fa);
                chk("gnt_b", gnt_b, fb);
                m_wea = fa && we_a;
                m_web = fb && we_b;
                if (fa) begin
                    m_addra = addr_a; m_dina = wdata_a;
                    if (we_a) mm[addr_a] = wdata_a;
                    else qa.push_back('{cyc + 1 + RD_LAT, mm[addr_a]});
                end
                if (fb) begin
                    m_addrb = addr_b; m_dinb = wdata_b;
                    if (we_b) mm[addr_b] = wdata_b;
                    else qb.push_back('{cyc + 1 + RD_LAT, mm[addr_b]});
                end
                if (conf) m_prio = !m_prio;
                if (cnt_clr) m_cnt = 0;
                else if (conf && m_cnt < 16'hFFFF) m_cnt = m_cnt + 1;
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic r, input logic w, input int ad, input int d);
        req_a = r; we_a = w; addr_a = ad[ADDR_W-1:0]; wdata_a = d;
    endtask

    task automatic set_b(input logic r, input logic w, input int ad, input int d);
        req_b = r; we_b = w; addr_b = ad[ADDR_W-1:0]; wdata_b = d;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        tick();

        // Write addr 5 then read it from B on the next edge
        set_a(1, 1, 5, 105); #1;
        chk("wr5_gnt_a", gnt_a, 1);
        tick();
        set_a(0, 0, 0, 0); set_b(1, 0, 5, 0);
        tick();
        set_b(0, 0, 0, 0); #1;
        chk("rd5_early_rvalid_b", rvalid_b, 0);
        tick();
        chk("rd5_rvalid_b", rvalid_b, 1);
        chk("rd5_rdata_b", rdata_b, 105);
        tick();
        chk("rd5_rvalid_b_drop", rvalid_b, 0);
        chk("rd5_cnt", conflict_cnt, 0);

        // Same-address write conflict: A wins first after reset
        set_a(1, 1, 7, 2); set_b(1, 1, 7, 20); #1;
        chk("c1_gnt_a", gnt_a, 1);
        chk("c1_gnt_b", gnt_b, 0);
        tick();
        set_a(0, 0, 0, 0); #1;
        chk("c1_gnt_b_next", gnt_b, 1);
        tick();
        set_b(0, 0, 0, 0); set_a(1, 0, 7, 0);
        tick();
        set_a(0, 0, 0, 0);
        tick();
        chk("c1_rvalid_a", rvalid_a, 1);
        chk("c1_rdata_a", rdata_a, 20);
        chk("c1_cnt", conflict_cnt, 1);

        // Pointer has rotated to B
        set_a(1, 0, 7, 0); set_b(1, 1, 7, 21); #1;
        chk("c2_gnt_b", gnt_b, 1);
        chk("c2_gnt_a", gnt_a, 0);
        tick();
        set_b(0, 0, 0, 0); #1;
        chk("c2_gnt_a_next", gnt_a, 1);
        tick();
        set_a(0, 0, 0, 0);
        tick();
        chk("c2_rvalid_a", rvalid_a, 1);
        chk("c2_rdata_a", rdata_a, 21);
        chk("c2_cnt", conflict_cnt, 2);

        // Parallel writes to different addresses, then shared read
        set_a(1, 1, 10, 12); set_b(1, 1, 11, 30); #1;
        chk("par_wr_gnt", {gnt_a, gnt_b}, 2'b11);
        tick();
        set_a(1, 0, 10, 0); set_b(1, 0, 10, 0); #1;
        chk("par_rd_gnt", {gnt_a, gnt_b}, 2'b11);
        tick();
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        tick();
        chk("par_rvalid", {rvalid_a, rvalid_b}, 2'b11);
        chk("par_rdata_a", rdata_a, 12);
        chk("par_rdata_b", rdata_b, 12);
        chk("par_cnt", conflict_cnt, 2);
        tick();

        // Read in flight when reset hits must be dropped
        set_a(1, 0, 10, 0);
        tick();
        rst = 1'b1; #1;
        chk("rst_mid_gnt_a", gnt_a, 0);
        chk("rst_mid_out", {rvalid_a, rvalid_b, ram_wea, ram_web, ram_addra, ram_addrb}, 0);
        chk("rst_mid_cnt", conflict_cnt, 0);
        tick();
        set_a(0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_after_rvalid_a", rvalid_a, 0);
        tick();

        // Saturation and clear precedence
        set_a(1, 1, 20, 1); set_b(1, 1, 20, 2);
        for (int i = 0; i < 70000; i++) tick();
        chk("sat_cnt", conflict_cnt, 16'hFFFF);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0; #1;
        chk("clr_cnt", conflict_cnt, 0);
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        tick(); tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
